// File: rtl/pipe_exe_muldiv.sv
// Iterative 32-bit multiply/divide unit for the EXE stage, holding architectural HI/LO.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; fixed 33-cycle latency.
module pipe_exe_muldiv (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        div0_q, div0_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] prod;
    logic [31:0] quo_fix, rem_fix;

    // op[0] selects signed, op[1] selects divide
    assign mag_a = (op[0] && a[31]) ? (~a + 32'd1) : a;
    assign mag_b = (op[0] && b[31]) ? (~b + 32'd1) : b;

    assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    assign div_shift = {rem_q, acc_q[31]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below 2^32, so the low word is exact
    assign div_diff  = div_shift[31:0] - opnd_q;

    assign prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix = rneg_q ? (~rem_q + 32'd1) : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        a_raw_d = a_raw_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;

        case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d = StRun;
                    cnt_d   = 6'd0;
                    op_d    = op;
                    a_raw_d = a;
                    rem_d   = 32'd0;
                    div0_d  = 1'b0;
                    neg_d   = op[0] & (a[31] ^ b[31]);
                    rneg_d  = op[0] & op[1] & a[31];
                    if (op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {32'd0, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {32'd0, mag_b};
                    end
                end else if (!start) begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[1]) begin
                        rem_d = div_ge ? div_diff : div_shift[31:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (opnd_q == 32'd0) begin
                        hi_d   = a_raw_q;
                        lo_d   = 32'hFFFF_FFFF;
                        div0_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            opnd_q  <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 32'd0;
            a_raw_q <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            a_raw_q <= a_raw_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign div0 = div0_q;

endmodule

// File: doc/pipe_exe_muldiv.md
# pipe_exe_muldiv

Iterative multiply/divide unit for the EXE stage of the five-stage pipeline; it produces the HI/LO results that the MEM stage later carries forward through the EXE/MEM register. It executes MULT, MULTU, DIV and DIVU over 33 cycles and raises `busy` so that pipeline control can stall the front end. It also holds the architectural HI/LO registers, written by MTHI/MTLO and read by MFHI/MFLO.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation; sampled only when `busy`=0
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `a`  in  32  rs operand (multiplicand / dividend)
- `b`  in  32  rt operand (multiplier / divisor)
- `flush`  in  1  abort in-flight operation (branch/exception squash)
- `hi_we`, `lo_we`  in  1 each  MTHI / MTLO write strobes
- `wdata`  in  32  MTHI/MTLO data
- `hi`, `lo`  out  32 each  architectural HI/LO, registered
- `busy`  out  1  operation in flight; pipeline must stall MFHI/MFLO/MTHI/MTLO/mul/div
- `done`  out  1  one-cycle pulse when HI/LO were just updated by an operation
- `div0`  out  1  last completed divide had `b`=0; held until next accepted `start`

## Operation
- FSM: IDLE, RUN, FIX.
- IDLE:
  - `start`=1 captures `op` and the operand magnitudes (signed ops take abs of `a`/`b`); records result sign.
  - Clears the 6-bit iteration counter and `div0`; moves to RUN.
- RUN:
  - One iteration per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per cycle, 33-bit partial remainder.
  - After iteration 32 moves to FIX.
- FIX:
  - Applies sign correction and writes HI/LO.
  - Pulses `done`; sets `div0` if divide with `b`=0; returns to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. MULT is two's-complement; MULTU is unsigned.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient negated if operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: LO = 32'hFFFFFFFF, HI = `a` (raw operand), `div0`=1, for both DIV and DIVU. Full latency still applies.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 32'h80000000, HI = 0, `div0`=0.
- MTHI/MTLO:
  - Write `hi`/`lo` at the clock edge only when state is IDLE and `start`=0.
  - Dropped if `start`=1 in the same cycle (start has priority) or if `busy`=1.
- `start` while `busy`=1 is ignored.
- `flush`:
  - In RUN or FIX: returns to IDLE next edge; HI/LO unchanged, no `done`, `div0` unchanged.
  - In IDLE: suppresses a same-cycle `start`.

## Timing
- Reset (async, `resetn`=0): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0, counter 0. Reset mid-operation discards the operation.
- Edge E0 accepts `start`; `busy`=1 from after E0.
- Iterations occur on edges E1–E32. E33 is FIX: HI/LO are written, `busy`=0 and `done`=1 for the cycle after E33.
- Total latency is 33 cycles from the accepting edge to visible result; it does not depend on the data.
- Back-to-back: `start` in the cycle where `done`=1 is accepted. That next E33 is 33 edges later.
- `busy` is registered (no combinational path from `start`). Control must stall the instruction that asserts `start` by decoding it combinationally.
- `hi`/`lo` change only at a FIX edge or an accepted MTHI/MTLO edge.

## Test plan
- Reset held, then released, no stimulus → `hi`=`lo`=0, `busy`=`done`=`div0`=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `busy` high 33 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` one cycle.
- MULT a=-3 (0xFFFFFFFD), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Immediately followed by DIV a=-7, b=2 in the `done` cycle → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, 33 cycles later.
- DIVU a=100, b=0 → `lo`=0xFFFFFFFF, `hi`=100, `div0`=1. Next accepted `start` clears `div0`.
- DIVU a=100, b=7 with `flush` pulsed at cycle 10 → returns IDLE, no `done`, `hi`/`lo` keep prior values. MTLO 0x1234 while busy → dropped.
- MTHI 0xAAAA0000 in IDLE → `hi`=0xAAAA0000 next edge. MTLO with `start` same cycle → write dropped, operation proceeds. `resetn` asserted at cycle 15 of a MULT → all outputs 0 immediately.
